// File: rtl/ikaopll_pkg.sv
// ikaopll_pkg: shared types and constants for the OPLL host-write scheduler.
package ikaopll_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} state_e;
   typedef enum logic [1:0] {CLS_GLOBAL, CLS_CHANNEL, CLS_UNMAPPED} cls_e;
   localparam int NUM_SLOTS = 18;
   localparam int NUM_CH = 9;
   localparam logic [7:0] GLB_LAST = 8'h07;
   localparam logic [7:0] GLB_X0 = 8'h0E;
   localparam logic [7:0] GLB_X1 = 8'h0F;
   localparam logic [1:0] BANK_FIRST = 2'd1;
   localparam logic [3:0] CH_LAST = 4'(NUM_CH - 1);
   // Channel banks live at 0x1x/0x2x/0x3x, each holding channels 0..8
   function automatic cls_e classify(input logic [7:0] a);
      return (a <= GLB_LAST || a == GLB_X0 || a == GLB_X1) ? CLS_GLOBAL :
             (a[7:6] == 2'd0 && a[5:4] >= BANK_FIRST && a[3:0] <= CH_LAST) ? CLS_CHANNEL :
             CLS_UNMAPPED;
   endfunction
endpackage

// File: rtl/ikaopll_slotcnt.sv
// ikaopll_slotcnt: 0..17 frame slot counter, resynchronised by the cycle-0 marker.
module ikaopll_slotcnt
   import ikaopll_pkg::*;
(
   input  logic       emuclk_i,
   input  logic       ic_n_i,
   input  logic       en_i,
   input  logic       cyc0_i,
   output logic [4:0] slot_o
);
   logic [4:0] slot_q, slot_d;
   always_comb slot_d = cyc0_i ? 5'd1 : (slot_q == 5'(NUM_SLOTS - 1)) ? 5'd0 : slot_q + 5'd1;
   always_ff @(posedge emuclk_i or negedge ic_n_i)
      if (!ic_n_i) slot_q <= '0;
      else if (en_i) slot_q <= slot_d;
   assign slot_o = slot_q;
endmodule

// File: rtl/ikaopll_wrsched.sv
// ikaopll_wrsched: holds host data writes until their frame commit slot, then
// strobes the register file for one phi1 period.
module ikaopll_wrsched
   import ikaopll_pkg::*;
#(
   parameter bit DROP_ON_BUSY = 1'b1
)
(
   input  logic       i_EMUCLK,
   input  logic       i_IC_n,
   input  logic       i_phi1_NCEN_n,
   input  logic       i_CYCLE_00,
   input  logic       i_CS_n,
   input  logic       i_WR_n,
   input  logic       i_A0,
   input  logic [7:0] i_D,
   output logic       o_REG_WE,
   output logic [5:0] o_REG_ADDR,
   output logic [7:0] o_REG_DATA,
   output logic       o_BUSY,
   output logic       o_OVF,
   output logic [4:0] o_SLOT
);
   logic en, stb, stb_q, ev, data_ev, mapped, acc, ovw, hit;
   logic we_q, busy_q, ovf_q;
   logic [7:0] addr_q, pdata_q, pdata_d;
   logic [5:0] paddr_q, paddr_d;
   logic [4:0] slot;
   cls_e cls, pcls_q, pcls_d;
   state_e state_q;

   assign en = ~i_phi1_NCEN_n;
   assign stb = ~i_CS_n & ~i_WR_n;
   assign ev = stb & ~stb_q;

   ikaopll_slotcnt u_slotcnt (
      .emuclk_i(i_EMUCLK),
      .ic_n_i  (i_IC_n),
      .en_i    (en),
      .cyc0_i  (i_CYCLE_00),
      .slot_o  (slot)
   );

   // An overwrite landing on a commit edge is judged against the new address
   always_comb begin
      cls = classify(addr_q);
      mapped = cls != CLS_UNMAPPED;
      data_ev = ev & i_A0 & mapped;
      acc = data_ev & (state_q == ST_IDLE);
      ovw = data_ev & (state_q == ST_WAIT) & ~DROP_ON_BUSY;
      paddr_d = (acc | ovw) ? addr_q[5:0] : paddr_q;
      pdata_d = (acc | ovw) ? i_D : pdata_q;
      pcls_d = (acc | ovw) ? cls : pcls_q;
      hit = (pcls_d == CLS_GLOBAL) | (slot == {1'b0, paddr_d[3:0]});
   end

   always_ff @(posedge i_EMUCLK or negedge i_IC_n)
      if (!i_IC_n) begin
         stb_q <= 1'b0;
         addr_q <= '0;
      end else begin
         stb_q <= stb;
         if (ev & ~i_A0) addr_q <= i_D;
      end

   always_ff @(posedge i_EMUCLK or negedge i_IC_n)
      if (!i_IC_n) begin
         state_q <= ST_IDLE;
         paddr_q <= '0;
         pdata_q <= '0;
         pcls_q <= CLS_UNMAPPED;
         we_q <= 1'b0;
         busy_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         paddr_q <= paddr_d;
         pdata_q <= pdata_d;
         pcls_q <= pcls_d;
         if (data_ev & (state_q != ST_IDLE)) ovf_q <= 1'b1;
         case (state_q)
            ST_IDLE: if (acc) begin
               state_q <= ST_WAIT;
               busy_q <= 1'b1;
            end
            ST_WAIT: if (en & hit) begin
               state_q <= ST_COMMIT;
               we_q <= 1'b1;
            end
            ST_COMMIT: if (en) begin
               state_q <= ST_IDLE;
               we_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end

   assign o_REG_WE = we_q;
   assign o_REG_ADDR = paddr_q;
   assign o_REG_DATA = pdata_q;
   assign o_BUSY = busy_q;
   assign o_OVF = ovf_q;
   assign o_SLOT = slot;
endmodule
